button_event_gen: RTL and testbench

//   Turns the debounced button level from the debouncer into discrete UI events.

---
 rtl/button_event_gen.sv | 122 ++++++++++++
 tb/tb_button_event_gen.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/button_event_gen.sv
// Turns the debounced button level into press, release, long-press and auto-repeat events.
// Latency: every event is a registered pulse one cycle after the clk edge that samples its cause.
// Backpressure: none; pulses are fire-and-forget and en=0 parks the block in IDLE.
module button_event_gen #(
    parameter int LONG_CYCLES   = 100_000_000,
    parameter int REPEAT_CYCLES = 20_000_000,
    parameter int CNT_W         = 27
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       db,
    input  logic       en,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       long_pulse,
    output logic       repeat_pulse,
    output logic       long_press,
    output logic       held,
    output logic [7:0] press_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HELD   = 2'd1,
        REPEAT = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] count, count_nxt;
    logic             db_q;
    logic             rise, fall;
    logic             press_nxt, release_nxt, long_nxt, repeat_nxt;

    assign rise = db & ~db_q;
    assign fall = ~db & db_q;

    always_comb begin
        state_nxt   = state;
        count_nxt   = count;
        press_nxt   = 1'b0;
        release_nxt = 1'b0;
        long_nxt    = 1'b0;
        repeat_nxt  = 1'b0;
        if (!en) begin
            state_nxt = IDLE;
            count_nxt = '0;
        end else begin
            case (state)
                IDLE: begin
                    count_nxt = '0;
                    if (rise) begin
                        press_nxt = 1'b1;
                        state_nxt = HELD;
                    end
                end
                HELD: begin
                    // A fall on the terminal cycle wins: the hold never became long.
                    if (fall) begin
                        release_nxt = 1'b1;
                        state_nxt   = IDLE;
                        count_nxt   = '0;
                    end else if (count == LONG_LAST) begin
                        long_nxt   = 1'b1;
                        repeat_nxt = 1'b1;
                        state_nxt  = REPEAT;
                        count_nxt  = '0;
                    end else begin
                        count_nxt = count + CNT_W'(1);
                    end
                end
                REPEAT: begin
                    if (fall) begin
                        release_nxt = 1'b1;
                        state_nxt   = IDLE;
                        count_nxt   = '0;
                    end else if (count == REPEAT_LAST) begin
                        repeat_nxt = 1'b1;
                        count_nxt  = '0;
                    end else begin
                        count_nxt = count + CNT_W'(1);
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    count_nxt = '0;
                end
            endcase
        end
    end

    // db_q resets high so a button already down at reset release is never a press.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            count         <= '0;
            db_q          <= 1'b1;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
            repeat_pulse  <= 1'b0;
            press_count   <= 8'd0;
        end else begin
            state         <= state_nxt;
            count         <= count_nxt;
            db_q          <= db;
            press_pulse   <= press_nxt;
            release_pulse <= release_nxt;
            long_pulse    <= long_nxt;
            repeat_pulse  <= repeat_nxt;
            if (press_nxt || repeat_nxt) begin
                press_count <= press_count + 8'd1;
            end
        end
    end

    assign held       = (state != IDLE);
    assign long_press = (state == REPEAT);

endmodule

// File: tb/tb_button_event_gen.sv
// Scoreboard bench for button_event_gen with LONG_CYCLES=8, REPEAT_CYCLES=4.
// Output vector order: {press, release, long, repeat, long_press, held, press_count[7:0]}.
module tb_button_event_gen;

    logic       clk = 1'b0;
    logic       reset;
    logic       db;
    logic       en;
    logic       press_pulse, release_pulse, long_pulse, repeat_pulse;
    logic       long_press, held;
    logic [7:0] press_count;

    logic [13:0] exp_q[$];
    logic [13:0] obs;
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  pc       = 8'd0;

    always #5 clk = ~clk;

    button_event_gen #(
        .LONG_CYCLES  (8),
        .REPEAT_CYCLES(4),
        .CNT_W        (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .db           (db),
        .en           (en),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .long_pulse   (long_pulse),
        .repeat_pulse (repeat_pulse),
        .long_press   (long_press),
        .held         (held),
        .press_count  (press_count)
    );

    assign obs = {press_pulse, release_pulse, long_pulse, repeat_pulse,
                  long_press, held, press_count};

    function automatic logic [13:0] pack(input logic p, input logic r, input logic l,
                                         input logic rp, input logic lp, input logic h,
                                         input logic [7:0] c);
        return {p, r, l, rp, lp, h, c};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [13:0] e;
        reset = 1'b1;
        db    = 1'b1;
        en    = 1'b1;
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(pack(0, 0, 0, 0, 0, 0, 8'd0));
            tick();
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL reset_state k=%0d got=%h exp=%h", k, obs, e);
            end
        end
        reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            db = (k < 4);
            exp_q.push_back(pack(0, 0, 0, 0, 0, 0, 8'd0));
            tick();
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL high_through_reset k=%0d got=%h exp=%h", k, obs, e);
            end
        end
        pc = 8'd0;
    endtask

    task automatic test_short_press();
        logic [13:0] e;
        for (int k = 0; k < 9; k++) begin
            db = (k <= 4);
            exp_q.push_back(pack(k == 0, k == 5, 0, 0, 0, k < 5, pc + 8'd1));
            tick();
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL short_press k=%0d got=%h exp=%h", k, obs, e);
            end
        end
        pc = pc + 8'd1;
    endtask

    task automatic test_long_hold();
        logic [13:0] e;
        logic [7:0]  c;
        for (int k = 0; k < 22; k++) begin
            db = (k <= 17);
            c  = pc + 8'd1 + 8'(k >= 8) + 8'(k >= 12) + 8'(k >= 16);
            exp_q.push_back(pack(k == 0, k == 18, k == 8, (k == 8) || (k == 12) || (k == 16),
                                 (k >= 8) && (k < 18), k < 18, c));
            tick();
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL long_hold k=%0d got=%h exp=%h", k, obs, e);
            end
        end
        pc = pc + 8'd4;
    endtask

    task automatic test_fall_at_terminal();
        logic [13:0] e;
        for (int k = 0; k < 11; k++) begin
            db = (k <= 7);
            exp_q.push_back(pack(k == 0, k == 8, 0, 0, 0, k < 8, pc + 8'd1));
            tick();
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL fall_at_terminal k=%0d got=%h exp=%h", k, obs, e);
            end
        end
        pc = pc + 8'd1;
    endtask

    task automatic test_enable();
        logic [13:0] e;
        for (int k = 0; k < 24; k++) begin
            db = (k < 20);
            en = !((k >= 10) && (k < 14));
            exp_q.push_back(pack(k == 0, 0, k == 8, k == 8, (k >= 8) && (k < 10), k < 10,
                                 pc + 8'd1 + 8'(k >= 8)));
            tick();
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL enable_gate k=%0d got=%h exp=%h", k, obs, e);
            end
        end
        en = 1'b1;
        pc = pc + 8'd2;
    endtask

    task automatic test_back_to_back();
        logic [13:0] e;
        for (int k = 0; k < 14; k++) begin
            db    = (k <= 11);
            reset = (k == 10);
            if (k < 10)
                exp_q.push_back(pack(k == 0, 0, k == 8, k == 8, k >= 8, 1,
                                     pc + 8'd1 + 8'(k >= 8)));
            else
                exp_q.push_back(pack(0, 0, 0, 0, 0, 0, 8'd0));
            tick();
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL reset_mid_repeat k=%0d got=%h exp=%h", k, obs, e);
            end
        end
        pc = 8'd0;
        for (int i = 0; i < 256; i++) begin
            for (int ph = 0; ph < 2; ph++) begin
                db = (ph == 0);
                exp_q.push_back(pack(ph == 0, ph == 1, 0, 0, 0, ph == 0, pc + 8'd1));
                tick();
                e = exp_q.pop_front();
                n_checks++;
                if (obs !== e) begin
                    n_fail++;
                    $display("FAIL wrap_press i=%0d ph=%0d got=%h exp=%h", i, ph, obs, e);
                end
            end
            pc = pc + 8'd1;
        end
        n_checks++;
        if (press_count !== 8'd0) begin
            n_fail++;
            $display("FAIL wrap_final got=%0d exp=0", press_count);
        end
    endtask

    initial begin
        reset = 1'b1;
        db    = 1'b0;
        en    = 1'b1;
        test_reset();
        test_short_press();
        test_long_hold();
        test_fall_at_terminal();
        test_enable();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
